if_id_stage: RTL and testbench
==============================

# if_id_stage

Consumer end of the fetch interface: the IF/ID pipeline register plus its hazard and flush control. Captures the fetched instruction and PC+4 every cycle, and drives the fetch stage's PC write enable. Also detects load-use hazards, inserts one bubble toward ID/EX, and squashes the wrong-path instruction on any taken redirect (branch, J, JR, TRAP). Sits between the fetch stage and the decode/register-file stage of the 5-stage MIPS pipeline.

## Interface
Parameters:
- NOP_WORD, 32'h00000000, instruction word loaded on flush/reset
- CNT_W, 16, width of the saturating performance counters

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- instruction_if  in  32  instruction from fetch
- nextpc_if  in  32  PC+4 from fetch
- redirect  in  1  OR of taken Z/J/JR/TRAP selects from fetch mux control
- ext_stall  in  1  pipeline freeze from multi-cycle unit (mult/div busy)
- id_ex_memread  in  1  instruction in EX is a load
- id_ex_rt  in  5  destination register of that load
- pc_ifwrite  out  1  PC write enable to fetch (combinational)
- instruction_id  out  32  registered instruction for decode
- nextpc_id  out  32  registered PC+4 for decode
- valid_id  out  1  instruction_id is a real, non-squashed instruction
- bubble_ex  out  1  force ID/EX control to zero this cycle (combinational)
- stall_cnt  out  CNT_W  cycles with pc_ifwrite=0, saturating
- flush_cnt  out  CNT_W  redirect flushes taken, saturating

## Operation
- Decode fields from instruction_id: rs=[25:21], rt=[20:16], op=[31:26]; uses_rt when op in {0x00, 0x04, 0x05, 0x2B}.
- hazard = valid_id & id_ex_memread & (id_ex_rt != 0) & (id_ex_rt == rs | (uses_rt & id_ex_rt == rt)).
- Per-cycle priority, highest first:
  - ext_stall: pc_ifwrite=0, IF/ID holds, bubble_ex=0, state unchanged.
  - redirect: pc_ifwrite=1; IF/ID loads NOP_WORD, valid_id=0, nextpc_id holds; flush_cnt+1; state→FLUSH.
  - hazard: pc_ifwrite=0; IF/ID holds; bubble_ex=1; state→LU_STALL.
  - otherwise: pc_ifwrite=1; IF/ID loads instruction_if/nextpc_if, valid_id=1; state→RUN.
- FSM states: RUN, LU_STALL, FLUSH (2-bit, encoding in package).
  - LU_STALL: hazard is not re-raised for the same instruction. If hazard is evaluated true again in LU_STALL, it is ignored, i.e. at most one bubble per load. Then normal load, →RUN.
  - FLUSH: valid_id=0, so hazard is inhibited. Next normal load →RUN. A redirect in FLUSH flushes again and stays in FLUSH.
- stall_cnt increments whenever pc_ifwrite=0 (ext_stall or hazard). Both counters saturate at all-ones.
- Reset mid-operation overrides everything, including ext_stall, in the same edge.

## Timing
- Reset values:
  - instruction_id=NOP_WORD, nextpc_id=0, valid_id=0
  - state=RUN, stall_cnt=0, flush_cnt=0
  - pc_ifwrite=1 and bubble_ex=0 while reset is high (combinational from reset state)
- Latency: fetch → decode is one cycle.
- Redirect squash: takes effect at the same edge that loads the target PC. The target instruction appears in instruction_id one cycle later.
- Load-use: exactly one bubble cycle; the dependent instruction re-presents to decode for 2 cycles total.
- pc_ifwrite and bubble_ex are pure combinational functions of current inputs and registered state; no input→output path through other combinational blocks.
- Simultaneous events: redirect+hazard → flush only, no bubble. ext_stall+redirect → hold; the redirect is honored on the first cycle ext_stall drops.

## Structure
- Shared package pipe_pkg: state enum, NOP_WORD, MIPS opcode constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_LW).
- One sub-module, load_use_detect: purely combinational hazard equation. Everything else stays in the top.

## Test plan
- Reset, then instruction_if=0x8C220004 with nextpc_if=0x04 → after one edge: instruction_id=0x8C220004, nextpc_id=0x04, valid_id=1, pc_ifwrite=1.
- instruction_id=0x00221820 (add r3,r1,r2), id_ex_memread=1, id_ex_rt=2 → pc_ifwrite=0, bubble_ex=1 for exactly 1 cycle; instruction_id held; stall_cnt=1.
- Same setup but id_ex_rt=0 → no hazard, pc_ifwrite=1.
- redirect=1 with instruction_if=0x12345678 → next instruction_id=0x00000000, valid_id=0, flush_cnt=1. Hazard inputs asserted at the same time produce no bubble.
- ext_stall=1 for 3 cycles with redirect=1 → outputs frozen, stall_cnt=3; flush occurs on the first cycle after ext_stall=0.
- Force stall_cnt to 0xFFFF via 65535+ stall cycles → stays 0xFFFF. Assert reset mid-stall → all outputs reach reset values after one edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID stage: FSM encoding, per-cycle action,
// reset instruction word and the MIPS opcodes the hazard logic inspects.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        FLUSH    = 2'b10
    } state_e;

    // What the IF/ID register does on the coming edge, already prioritised.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'b00,
        ACT_HOLD   = 2'b01,
        ACT_FLUSH  = 2'b10,
        ACT_BUBBLE = 2'b11
    } action_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LW    = 6'h23;

    // Opcodes that read rt as a source operand.
    function automatic logic uses_rt(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch <-> IF/ID handshake: fetched word, PC+4, taken-redirect flag,
// and the PC write enable returned to fetch.
interface if_id_stage_if;
    logic [31:0] instruction_if;
    logic [31:0] nextpc_if;
    logic        redirect;
    logic        pc_ifwrite;

    modport master (
        output instruction_if,
        output nextpc_if,
        output redirect,
        input  pc_ifwrite
    );

    modport slave (
        input  instruction_if,
        input  nextpc_if,
        input  redirect,
        output pc_ifwrite
    );
endinterface

// File: rtl/if_id_stage_load_use_detect.sv
// Combinational load-use hazard check between the instruction in decode
// and a load currently in EX.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic [5:0] op,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt == rs);
    assign rt_match = uses_rt(op) && (ex_rt == rt);

    // A load into r0 never produces a value worth waiting for.
    assign hazard = valid && ex_memread && (ex_rt != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use bubble insertion, redirect squash,
// external freeze and saturating stall/flush counters.
module if_id_stage #(
    parameter logic [31:0] NOP_WORD = pipe_pkg::NOP_WORD,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    if_id_stage_if.slave      fetch,
    input  logic              ext_stall,
    input  logic              id_ex_memread,
    input  logic [4:0]        id_ex_rt,
    output logic [31:0]       instruction_id,
    output logic [31:0]       nextpc_id,
    output logic              valid_id,
    output logic              bubble_ex,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    import pipe_pkg::*;

    state_e  state_q;
    state_e  state_d;
    action_e act;
    logic    hazard_raw;
    logic    hazard;

    load_use_detect u_load_use_detect (
        .op         (instruction_id[31:26]),
        .rs         (instruction_id[25:21]),
        .rt         (instruction_id[20:16]),
        .valid      (valid_id),
        .ex_memread (id_ex_memread),
        .ex_rt      (id_ex_rt),
        .hazard     (hazard_raw)
    );

    // Only one bubble per load: the re-presented instruction is let through.
    assign hazard = hazard_raw && (state_q != LU_STALL);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        act     = ACT_LOAD;
        state_d = RUN;
        if (ext_stall) begin
            act     = ACT_HOLD;
            state_d = state_q;
        end else if (fetch.redirect) begin
            act     = ACT_FLUSH;
            state_d = FLUSH;
        end else if (hazard) begin
            act     = ACT_BUBBLE;
            state_d = LU_STALL;
        end
    end

    // Reset forces the fetch-side controls to their idle values immediately.
    assign fetch.pc_ifwrite = reset || (act == ACT_LOAD) || (act == ACT_FLUSH);
    assign bubble_ex        = !reset && (act == ACT_BUBBLE);

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            instruction_id <= NOP_WORD;
            nextpc_id      <= 32'h0;
            valid_id       <= 1'b0;
        end else begin
            state_q <= state_d;
            case (act)
                ACT_LOAD: begin
                    instruction_id <= fetch.instruction_if;
                    nextpc_id      <= fetch.nextpc_if;
                    valid_id       <= 1'b1;
                end
                ACT_FLUSH: begin
                    instruction_id <= NOP_WORD;
                    valid_id       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((act == ACT_HOLD || act == ACT_BUBBLE) && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (act == ACT_FLUSH && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a cycle-level reference model checked every
// cycle, plus hand-computed literal expectations along the stimulus.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ext_stall;
    logic        id_ex_memread;
    logic [4:0]  id_ex_rt;
    logic [31:0] instruction_id;
    logic [31:0] nextpc_id;
    logic        valid_id;
    logic        bubble_ex;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    if_id_stage_if fif ();

    if_id_stage #(.NOP_WORD(32'h0000_0000), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch          (fif),
        .ext_stall      (ext_stall),
        .id_ex_memread  (id_ex_memread),
        .id_ex_rt       (id_ex_rt),
        .instruction_id (instruction_id),
        .nextpc_id      (nextpc_id),
        .valid_id       (valid_id),
        .bubble_ex      (bubble_ex),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what decode holds, whether the held instruction has
    // already cost its one bubble, and the two event counts.
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_bubbled;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    function automatic bit m_hazard();
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        bit         reads_rt;
        op = m_instr[31:26];
        rs = m_instr[25:21];
        rt = m_instr[20:16];
        reads_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
        return m_valid && !m_bubbled && id_ex_memread && (id_ex_rt != 0)
               && ((id_ex_rt == rs) || (reads_rt && id_ex_rt == rt));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_instr   <= 32'h0;
            m_pc      <= 32'h0;
            m_valid   <= 1'b0;
            m_bubbled <= 1'b0;
            m_stall   <= 0;
            m_flush   <= 0;
        end else if (ext_stall) begin
            m_stall <= (m_stall < 65535) ? m_stall + 1 : m_stall;
        end else if (fif.redirect) begin
            m_instr   <= 32'h0;
            m_valid   <= 1'b0;
            m_bubbled <= 1'b0;
            m_flush   <= (m_flush < 65535) ? m_flush + 1 : m_flush;
        end else if (m_hazard()) begin
            m_bubbled <= 1'b1;
            m_stall   <= (m_stall < 65535) ? m_stall + 1 : m_stall;
        end else begin
            m_instr   <= fif.instruction_if;
            m_pc      <= fif.nextpc_if;
            m_valid   <= 1'b1;
            m_bubbled <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit haz;
            bit exp_pcw;
            bit exp_bub;
            haz     = m_hazard();
            exp_pcw = reset || (!ext_stall && (fif.redirect || !haz));
            exp_bub = !reset && !ext_stall && !fif.redirect && haz;
            check("model instruction_id", instruction_id, m_instr);
            check("model nextpc_id", nextpc_id, m_pc);
            check("model valid_id", {31'b0, valid_id}, {31'b0, m_valid});
            check("model stall_cnt", {16'b0, stall_cnt}, m_stall);
            check("model flush_cnt", {16'b0, flush_cnt}, m_flush);
            check("model pc_ifwrite", {31'b0, fif.pc_ifwrite}, {31'b0, exp_pcw});
            check("model bubble_ex", {31'b0, bubble_ex}, {31'b0, exp_bub});
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset             = 1'b1;
        ext_stall         = 1'b1;
        id_ex_memread     = 1'b0;
        id_ex_rt          = 5'd0;
        fif.instruction_if = 32'h8C22_0004;
        fif.nextpc_if     = 32'h0000_0004;
        fif.redirect      = 1'b0;
        tick();
        chk_en = 1'b1;
        check("reset pc_ifwrite", {31'b0, fif.pc_ifwrite}, 32'd1);
        check("reset bubble_ex", {31'b0, bubble_ex}, 32'd0);
        check("reset instruction_id", instruction_id, 32'h0);
        check("reset valid_id", {31'b0, valid_id}, 32'd0);
        check("reset stall_cnt", {16'b0, stall_cnt}, 32'd0);
        reset     = 1'b0;
        ext_stall = 1'b0;

        // Plain fetch -> decode, one cycle.
        tick();
        check("load instruction_id", instruction_id, 32'h8C22_0004);
        check("load nextpc_id", nextpc_id, 32'h0000_0004);
        check("load valid_id", {31'b0, valid_id}, 32'd1);
        // lw does not read rt, so a load into its rt is not a hazard.
        id_ex_memread = 1'b1;
        id_ex_rt      = 5'd2;
        #1;
        check("lw rt no hazard pcw", {31'b0, fif.pc_ifwrite}, 32'd1);
        check("lw rt no hazard bubble", {31'b0, bubble_ex}, 32'd0);
        id_ex_memread = 1'b0;

        // Load-use on add r3,r1,r2 with load into r2.
        fif.instruction_if = 32'h0022_1820;
        fif.nextpc_if      = 32'h0000_0008;
        tick();
        id_ex_memread      = 1'b1;
        id_ex_rt           = 5'd2;
        fif.instruction_if = 32'h2064_0001;
        fif.nextpc_if      = 32'h0000_000C;
        #1;
        check("hazard pcw", {31'b0, fif.pc_ifwrite}, 32'd0);
        check("hazard bubble", {31'b0, bubble_ex}, 32'd1);
        tick();
        check("hazard held instr", instruction_id, 32'h0022_1820);
        check("hazard stall_cnt", {16'b0, stall_cnt}, 32'd1);
        check("second cycle pcw", {31'b0, fif.pc_ifwrite}, 32'd1);
        check("second cycle bubble", {31'b0, bubble_ex}, 32'd0);
        tick();
        check("after bubble instr", instruction_id, 32'h2064_0001);
        id_ex_memread = 1'b0;

        // Load into r0 never stalls.
        fif.instruction_if = 32'h0000_1820;
        fif.nextpc_if      = 32'h0000_0010;
        tick();
        id_ex_memread = 1'b1;
        id_ex_rt      = 5'd0;
        #1;
        check("r0 no hazard pcw", {31'b0, fif.pc_ifwrite}, 32'd1);
        id_ex_memread = 1'b0;

        // Redirect with a live hazard: flush only.
        fif.instruction_if = 32'h0022_1820;
        fif.nextpc_if      = 32'h0000_0014;
        tick();
        id_ex_memread      = 1'b1;
        id_ex_rt           = 5'd2;
        fif.redirect       = 1'b1;
        fif.instruction_if = 32'h1234_5678;
        fif.nextpc_if      = 32'h0000_0018;
        #1;
        check("redirect+hazard pcw", {31'b0, fif.pc_ifwrite}, 32'd1);
        check("redirect+hazard bubble", {31'b0, bubble_ex}, 32'd0);
        tick();
        check("flush instr", instruction_id, 32'h0);
        check("flush valid", {31'b0, valid_id}, 32'd0);
        check("flush nextpc held", nextpc_id, 32'h0000_0014);
        check("flush flush_cnt", {16'b0, flush_cnt}, 32'd1);
        id_ex_memread      = 1'b0;
        fif.redirect       = 1'b0;
        fif.instruction_if = 32'h8C22_0004;
        fif.nextpc_if      = 32'h0000_0104;
        tick();
        check("target instr", instruction_id, 32'h8C22_0004);
        check("target valid", {31'b0, valid_id}, 32'd1);

        // Freeze with a pending redirect.
        ext_stall          = 1'b1;
        fif.redirect       = 1'b1;
        fif.instruction_if = 32'hDEAD_BEEF;
        fif.nextpc_if      = 32'h0000_0200;
        #1;
        check("freeze pcw", {31'b0, fif.pc_ifwrite}, 32'd0);
        repeat (3) tick();
        check("freeze instr held", instruction_id, 32'h8C22_0004);
        check("freeze stall_cnt", {16'b0, stall_cnt}, 32'd4);
        check("freeze flush_cnt", {16'b0, flush_cnt}, 32'd1);
        ext_stall = 1'b0;
        #1;
        check("unfreeze pcw", {31'b0, fif.pc_ifwrite}, 32'd1);
        tick();
        check("late flush instr", instruction_id, 32'h0);
        check("late flush flush_cnt", {16'b0, flush_cnt}, 32'd2);
        fif.redirect = 1'b0;
        tick();

        // Saturate the stall counter, then reset mid-stall.
        ext_stall = 1'b1;
        repeat (65540) tick();
        check("stall_cnt saturated", {16'b0, stall_cnt}, 32'h0000_FFFF);
        repeat (3) tick();
        check("stall_cnt stays", {16'b0, stall_cnt}, 32'h0000_FFFF);
        reset = 1'b1;
        #1;
        check("reset-in-stall pcw", {31'b0, fif.pc_ifwrite}, 32'd1);
        check("reset-in-stall bubble", {31'b0, bubble_ex}, 32'd0);
        tick();
        check("mid reset instr", instruction_id, 32'h0);
        check("mid reset nextpc", nextpc_id, 32'h0);
        check("mid reset valid", {31'b0, valid_id}, 32'd0);
        check("mid reset stall_cnt", {16'b0, stall_cnt}, 32'd0);
        check("mid reset flush_cnt", {16'b0, flush_cnt}, 32'd0);
        reset     = 1'b0;
        ext_stall = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
